// File: rtl/wait_event_if.sv
// Command, sample and result signals of the multi-channel event waiter.
// master drives commands and channel samples; slave is the waiter.
interface wait_event_if #(
    parameter int WAIT_SIZE  = 4,
    parameter int WAIT_WIDTH = 8,
    parameter int SEL_W      = 2,
    parameter int BIT_W      = 3,
    parameter int OCC_W      = 4,
    parameter int TO_W       = 16
);
    logic [WAIT_SIZE*WAIT_WIDTH-1:0] i_wait;
    logic                            i_cmd_valid;
    logic                            o_cmd_ready;
    logic [2:0]                      i_cmd_op;
    logic [SEL_W-1:0]                i_cmd_sel;
    logic [BIT_W-1:0]                i_cmd_bit;
    logic [OCC_W-1:0]                i_cmd_occ;
    logic [TO_W-1:0]                 i_cmd_timeout;
    logic                            i_abort;
    logic                            o_wait_done;
    logic [1:0]                      o_status;
    logic [TO_W-1:0]                 o_elapsed;
    logic                            o_busy;

    modport master (
        output i_wait, i_cmd_valid, i_cmd_op, i_cmd_sel,
        output i_cmd_bit, i_cmd_occ, i_cmd_timeout, i_abort,
        input  o_cmd_ready, o_wait_done, o_status,
        input  o_elapsed, o_busy
    );

    modport slave (
        input  i_wait, i_cmd_valid, i_cmd_op, i_cmd_sel,
        input  i_cmd_bit, i_cmd_occ, i_cmd_timeout, i_abort,
        output o_cmd_ready, o_wait_done, o_status,
        output o_elapsed, o_busy
    );
endinterface

// File: rtl/wait_event_mc.sv
// Multi-channel event waiter: edge/level modes, N-occurrence counting,
// cycle-exact timeout, abort and elapsed-cycle reporting.
module wait_event_mc #(
    parameter int WAIT_SIZE  = 4,
    parameter int WAIT_WIDTH = 8,
    parameter int SEL_W      = 2,
    parameter int BIT_W      = 3,
    parameter int OCC_W      = 4,
    parameter int TO_W       = 16
) (
    input logic        clk,
    input logic        rst,
    wait_event_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARM, WAIT, DONE} state_t;

    localparam logic [2:0] OP_WTR = 3'd0;
    localparam logic [2:0] OP_WTF = 3'd1;
    localparam logic [2:0] OP_WTH = 3'd2;
    localparam logic [2:0] OP_WTL = 3'd3;
    localparam logic [2:0] OP_WTE = 3'd4;

    localparam logic [1:0] ST_MATCH   = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORT   = 2'd2;
    localparam logic [1:0] ST_ILLEGAL = 2'd3;

    state_t state;

    logic [WAIT_SIZE-1:0][WAIT_WIDTH-1:0] s_cur;
    logic [WAIT_SIZE-1:0][WAIT_WIDTH-1:0] s_prev;

    logic [2:0]       op;
    logic [SEL_W-1:0] sel;
    logic [BIT_W-1:0] bsel;
    logic [OCC_W-1:0] occ;
    logic [TO_W-1:0]  tmo;
    logic [OCC_W-1:0] hits;
    logic [TO_W-1:0]  cyc;

    logic            ready, done, busy;
    logic [1:0]      status;
    logic [TO_W-1:0] elapsed;

    logic            legal;
    logic            b, p, hit, match, to_hit;
    logic [TO_W-1:0] cyc_inc;
    logic            fin;
    logic [1:0]      fin_st;
    logic [TO_W-1:0] fin_el;

    assign legal = (bus.i_cmd_op <= OP_WTE)
                 && (int'(bus.i_cmd_sel) < WAIT_SIZE)
                 && (int'(bus.i_cmd_bit) < WAIT_WIDTH);

    always_comb begin
        b   = s_cur[sel][bsel];
        p   = s_prev[sel][bsel];
        hit = 1'b0;
        unique case (1'b1)
            op == OP_WTR: hit = ~p & b;
            op == OP_WTF: hit = p & ~b;
            op == OP_WTH: hit = b;
            op == OP_WTL: hit = ~b;
            op == OP_WTE: hit = p ^ b;
            default:      hit = 1'b0;
        endcase
    end

    // With no timeout the counter pins at all-ones instead of wrapping.
    assign cyc_inc = (cyc == '1) ? cyc : cyc + 1'b1;
    assign match   = hit && (hits + OCC_W'(1) == occ);
    assign to_hit  = (tmo != '0) && (cyc_inc == tmo);

    always_comb begin
        fin    = 1'b0;
        fin_st = ST_MATCH;
        fin_el = cyc_inc;
        if (state == ARM && bus.i_abort) begin
            fin    = 1'b1;
            fin_st = ST_ABORT;
            fin_el = '0;
        end else if (state == WAIT) begin
            if (bus.i_abort) begin
                fin    = 1'b1;
                fin_st = ST_ABORT;
                fin_el = cyc;
            end else if (match) begin
                fin    = 1'b1;
                fin_st = ST_MATCH;
            end else if (to_hit) begin
                fin    = 1'b1;
                fin_st = ST_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            s_cur   <= '0;
            s_prev  <= '0;
            op      <= '0;
            sel     <= '0;
            bsel    <= '0;
            occ     <= '0;
            tmo     <= '0;
            hits    <= '0;
            cyc     <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b0;
            status  <= ST_MATCH;
            elapsed <= '0;
        end else begin
            s_cur  <= bus.i_wait;
            s_prev <= s_cur;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_cmd_valid && legal) begin
                        op    <= bus.i_cmd_op;
                        sel   <= bus.i_cmd_sel;
                        bsel  <= bus.i_cmd_bit;
                        occ   <= (bus.i_cmd_occ == '0) ? OCC_W'(1)
                                                       : bus.i_cmd_occ;
                        tmo   <= bus.i_cmd_timeout;
                        state <= ARM;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end else if (bus.i_cmd_valid) begin
                        state   <= DONE;
                        ready   <= 1'b0;
                        done    <= 1'b1;
                        status  <= ST_ILLEGAL;
                        elapsed <= '0;
                    end
                end
                ARM: begin
                    hits  <= '0;
                    cyc   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    hits <= hits + OCC_W'(hit);
                    cyc  <= cyc_inc;
                end
                DONE: begin
                    state <= IDLE;
                    ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (fin) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                status  <= fin_st;
                elapsed <= fin_el;
            end
        end
    end

    assign bus.o_cmd_ready = ready;
    assign bus.o_wait_done = done;
    assign bus.o_status    = status;
    assign bus.o_elapsed   = elapsed;
    assign bus.o_busy      = busy;
endmodule

// File: tb/tb_wait_event_mc.sv
// Bench for wait_event_mc: history-based reference model checked every
// cycle, plus directed scenarios with literal expected results.
module tb_wait_event_mc;
    localparam int WS = 3;
    localparam int WW = 6;
    localparam int SW = 2;
    localparam int BW = 3;
    localparam int OW = 4;
    localparam int TW = 16;
    localparam int W  = WS * WW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]  wv    = '0;
    logic          valid = 1'b0;
    logic [2:0]    op_v  = '0;
    logic [SW-1:0] sel_v = '0;
    logic [BW-1:0] bit_v = '0;
    logic [OW-1:0] occ_v = '0;
    logic [TW-1:0] to_v  = '0;
    logic          abort = 1'b0;

    wait_event_if #(
        .WAIT_SIZE(WS), .WAIT_WIDTH(WW), .SEL_W(SW),
        .BIT_W(BW), .OCC_W(OW), .TO_W(TW)
    ) bus ();

    assign bus.i_wait        = wv;
    assign bus.i_cmd_valid   = valid;
    assign bus.i_cmd_op      = op_v;
    assign bus.i_cmd_sel     = sel_v;
    assign bus.i_cmd_bit     = bit_v;
    assign bus.i_cmd_occ     = occ_v;
    assign bus.i_cmd_timeout = to_v;
    assign bus.i_abort       = abort;

    wait_event_mc #(
        .WAIT_SIZE(WS), .WAIT_WIDTH(WW), .SEL_W(SW),
        .BIT_W(BW), .OCC_W(OW), .TO_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Reference model: remembers every cycle's sampled input and abort,
    // and decides the outcome of an active wait by recounting hits
    // over the whole wait window.
    logic [W-1:0] wh [0:2047];
    bit           ah [0:2047];
    bit act_m = 0, indone = 0;
    int t0, m_op, m_sel, m_bit, m_occ, m_to;
    bit e_done = 0, e_rdy = 1, e_busy = 0;
    int e_st = 0, e_el = 0;

    function automatic bit hit_at(int j);
        int idx;
        bit b, p;
        idx = m_sel * WW + m_bit;
        b = wh[j-1][idx];
        p = wh[j-2][idx];
        case (m_op)
            0: return !p && b;
            1: return p && !b;
            2: return b;
            3: return !b;
            default: return p != b;
        endcase
    endfunction

    always @(posedge clk) begin : model
        int n, el;
        bit fin;
        wh[cyc] = rst ? '0 : wv;
        ah[cyc] = abort;
        if (rst) begin
            act_m = 0; indone = 0;
            e_done = 0; e_rdy = 1; e_busy = 0; e_st = 0; e_el = 0;
        end else if (indone) begin
            indone = 0; e_done = 0; e_rdy = 1;
        end else if (!act_m) begin
            if (valid) begin
                if (int'(op_v) > 4 || int'(sel_v) >= WS
                    || int'(bit_v) >= WW) begin
                    indone = 1; e_done = 1; e_rdy = 0;
                    e_st = 3; e_el = 0;
                end else begin
                    act_m = 1; t0 = cyc; e_rdy = 0; e_busy = 1;
                    m_op = int'(op_v); m_sel = int'(sel_v);
                    m_bit = int'(bit_v); m_to = int'(to_v);
                    m_occ = (occ_v == 0) ? 1 : int'(occ_v);
                end
            end
        end else begin
            fin = 0;
            el = cyc - t0 - 1;
            if (ah[cyc]) begin
                fin = 1; e_st = 2;
                e_el = (cyc == t0 + 1) ? 0 : cyc - t0 - 2;
            end else if (cyc >= t0 + 2) begin
                n = 0;
                for (int j = t0 + 2; j <= cyc; j++) n += int'(hit_at(j));
                if (n >= m_occ) begin
                    fin = 1; e_st = 0; e_el = el;
                end else if (m_to != 0 && el == m_to) begin
                    fin = 1; e_st = 1; e_el = el;
                end
            end
            if (fin) begin
                act_m = 0; indone = 1; e_done = 1; e_busy = 0;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("done",    32'(bus.o_wait_done), 32'(e_done));
            chk("ready",   32'(bus.o_cmd_ready), 32'(e_rdy));
            chk("busy",    32'(bus.o_busy),      32'(e_busy));
            chk("status",  32'(bus.o_status),    e_st);
            chk("elapsed", 32'(bus.o_elapsed),   e_el);
        end
    end

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go(int c);
        while (cyc < c) step();
    endtask

    task automatic issue(input int op, input int s, input int bt,
                         input int oc, input int to, output int t);
        op_v  = 3'(op);
        sel_v = SW'(s);
        bit_v = BW'(bt);
        occ_v = OW'(oc);
        to_v  = TW'(to);
        valid = 1'b1;
        t = cyc;
        step();
        valid = 1'b0;
    endtask

    task automatic lit(string nm, int c, int st, int el);
        go(c);
        chk({nm, "_done"},    32'(bus.o_wait_done), 1);
        chk({nm, "_status"},  32'(bus.o_status),    st);
        chk({nm, "_elapsed"}, 32'(bus.o_elapsed),   el);
    endtask

    task automatic setb(int ch, int b, bit v);
        wv[ch*WW + b] = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t;
        step();
        chk("rst_ready",   32'(bus.o_cmd_ready), 1);
        chk("rst_done",    32'(bus.o_wait_done), 0);
        chk("rst_busy",    32'(bus.o_busy),      0);
        chk("rst_status",  32'(bus.o_status),    0);
        chk("rst_elapsed", 32'(bus.o_elapsed),   0);
        step(2);
        rst = 1'b0;
        step(2);

        issue(0, 1, 3, 1, 0, t);
        go(t + 5); setb(1, 3, 1);
        lit("wtr", t + 7, 0, 5);
        step(2); wv = '0;

        setb(0, 0, 1); step(3);
        issue(1, 0, 0, 1, 10, t);
        lit("wtf_to", t + 12, 1, 10);
        step(2);
        issue(1, 0, 0, 1, 10, t);
        go(t + 10); setb(0, 0, 0);
        lit("wtf_last", t + 12, 0, 10);
        step(2);

        issue(4, 2, 5, 3, 0, t);
        go(t + 3); setb(2, 5, 1);
        go(t + 6); setb(2, 5, 0);
        go(t + 9); setb(2, 5, 1);
        lit("wte3", t + 11, 0, 9);
        step(2);
        issue(2, 2, 5, 0, 0, t);
        lit("wth", t + 3, 0, 1);
        step(2);
        issue(3, 2, 4, 3, 0, t);
        lit("wtl3", t + 5, 0, 3);
        step(2);

        issue(0, 1, 2, 1, 0, t);
        go(t + 6); abort = 1'b1;
        step(); abort = 1'b0;
        lit("abort", t + 7, 2, 4);
        go(t + 8);
        chk("abort_ready", 32'(bus.o_cmd_ready), 1);
        issue(3, 1, 2, 1, 0, t);
        lit("after_abort", t + 3, 0, 1);
        step(2);

        issue(0, 0, 1, 1, 3, t);
        go(t + 3); setb(0, 1, 1);
        lit("match_vs_to", t + 5, 0, 3);
        setb(0, 1, 0); step(3);

        issue(6, 0, 0, 1, 0, t);
        lit("ill_op", t + 1, 3, 0);
        step(2);
        issue(0, WS, 0, 1, 0, t);
        lit("ill_sel", t + 1, 3, 0);
        step(2);
        issue(0, 0, WW, 1, 0, t);
        lit("ill_bit", t + 1, 3, 0);
        step(2);

        issue(0, 0, 2, 1, 0, t);
        abort = 1'b1; step(); abort = 1'b0;
        lit("abort_arm", t + 2, 2, 0);
        step(2);
        abort = 1'b1; step(); abort = 1'b0;
        step();
        chk("idle_abort", 32'(bus.o_wait_done), 0);

        issue(0, 0, 3, 1, 0, t);
        go(t + 4); rst = 1'b1;
        step(); rst = 1'b0;
        chk("rst_mid_ready", 32'(bus.o_cmd_ready), 1);
        chk("rst_mid_busy",  32'(bus.o_busy),      0);
        step(4);

        setb(0, 1, 1); step();
        issue(0, 0, 1, 1, 5, t);
        lit("early_rise", t + 7, 1, 5);
        setb(0, 1, 0); step(3);

        op_v = 3'd2; sel_v = 2'd2; bit_v = 3'd5;
        occ_v = 4'd1; to_v = '0;
        valid = 1'b1; t = cyc;
        lit("hold1", t + 3, 0, 1);
        chk("hold_ready_done", 32'(bus.o_cmd_ready), 0);
        go(t + 4);
        chk("hold_ready_idle", 32'(bus.o_cmd_ready), 1);
        step(); valid = 1'b0;
        chk("hold_busy", 32'(bus.o_busy), 1);
        lit("hold2", t + 7, 0, 1);

        step(5);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
